// File: rtl/adder_bist.sv
// Built-in self-test sequencer for the 8-bit top-level adder: drives operand pairs,
// checks the returned sum against (A+B) mod 256, and reports pass/fail, error count and first failing index.
module adder_bist #(
  parameter int         NUM_VECTORS = 64,
  parameter int         LAT         = 0,
  parameter logic [7:0] SEED        = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  op_a,
  output logic [7:0]  op_b,
  input  logic [7:0]  sum_in,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [7:0]  err_count,
  output logic        fail_valid,
  output logic [15:0] fail_idx
);

  localparam logic [7:0]  SEED_EFF  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
  localparam logic [1:0]  WAIT_LAST = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] k_idx;
  logic [15:0] k_next;
  logic [7:0]  lfsr;
  logic [1:0]  wait_cnt;
  logic [7:0]  expected;
  logic        mismatch;

  // Galois step for x^8+x^6+x^5+x^4+1
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Fixed corner operand pairs {A,B} for the first four vectors
  function automatic logic [15:0] corner(input logic [1:0] k);
    case (k)
      2'd0:    return 16'h0101;
      2'd1:    return 16'h0F01;
      2'd2:    return 16'hFF01;
      default: return 16'hAA55;
    endcase
  endfunction

  assign k_next   = k_idx + 16'd1;
  assign expected = op_a + op_b;
  assign mismatch = (sum_in != expected);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_DRIVE;
      S_DRIVE:        state_nxt = (LAT > 0) ? S_WAIT : S_CHECK;
      S_WAIT:         if (wait_cnt == WAIT_LAST) state_nxt = S_CHECK;
      S_CHECK:        state_nxt = (k_idx == LAST_IDX) ? S_DONE : S_DRIVE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    done = (state == S_DONE);
    pass = (state == S_DONE) && (err_count == 8'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_idx      <= 16'd0;
      op_a       <= 8'd0;
      op_b       <= 8'd0;
      lfsr       <= SEED_EFF;
      wait_cnt   <= 2'd0;
      err_count  <= 8'd0;
      fail_valid <= 1'b0;
      fail_idx   <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            k_idx        <= 16'd0;
            {op_a, op_b} <= corner(2'd0);
            lfsr         <= SEED_EFF;
            wait_cnt     <= 2'd0;
            err_count    <= 8'd0;
            fail_valid   <= 1'b0;
            fail_idx     <= 16'd0;
          end
        end
        S_DRIVE: wait_cnt <= 2'd0;
        S_WAIT:  wait_cnt <= wait_cnt + 2'd1;
        S_CHECK: begin
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_idx   <= k_idx;
            end
          end
          // The LFSR holds the operand for the next pseudo-random vector
          if (k_idx != LAST_IDX) begin
            k_idx <= k_next;
            if (k_next < 16'd4) begin
              {op_a, op_b} <= corner(k_next[1:0]);
            end else begin
              op_a <= lfsr;
              op_b <= k_next[7:0];
              lfsr <= lfsr_step(lfsr);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_bist.sv
// Directed bench for adder_bist: ideal, stuck-bit, saturating and pipelined adder models,
// mid-run reset and start-while-busy behaviour.
module tb_adder_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_l0 = 1'b0;
  logic        start_l2 = 1'b0;
  int          mode = 0;
  int          checks = 0;
  int          failures = 0;

  logic [7:0]  op_a_l0, op_b_l0, sum_l0, err_l0;
  logic        busy_l0, done_l0, pass_l0, fv_l0;
  logic [15:0] fidx_l0;
  logic [7:0]  op_a_l2, op_b_l2, sum_l2, err_l2;
  logic        busy_l2, done_l2, pass_l2, fv_l2;
  logic [15:0] fidx_l2;
  logic [7:0]  sum_l0_p1, sum_l0_p2, sum_l2_p1, sum_l2_p2;

  logic [7:0]  log_a [64];
  logic [7:0]  log_b [64];
  logic [7:0]  ref_a [64];
  logic [7:0]  ref_b [64];

  always #5 clk = ~clk;

  adder_bist #(.NUM_VECTORS(64), .LAT(0), .SEED(8'hA5)) u_l0 (
    .clk(clk), .rst(rst), .start(start_l0), .op_a(op_a_l0), .op_b(op_b_l0),
    .sum_in(sum_l0), .busy(busy_l0), .done(done_l0), .pass(pass_l0),
    .err_count(err_l0), .fail_valid(fv_l0), .fail_idx(fidx_l0));

  adder_bist #(.NUM_VECTORS(64), .LAT(2), .SEED(8'hA5)) u_l2 (
    .clk(clk), .rst(rst), .start(start_l2), .op_a(op_a_l2), .op_b(op_b_l2),
    .sum_in(sum_l2), .busy(busy_l2), .done(done_l2), .pass(pass_l2),
    .err_count(err_l2), .fail_valid(fv_l2), .fail_idx(fidx_l2));

  // mode: 0 ideal, 1 bit 7 stuck at 0, 2 saturating, 3 registered two deep
  function automatic logic [7:0] adder_fn(input logic [7:0] a, input logic [7:0] b, input int md);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    case (md)
      1:       return {1'b0, s[6:0]};
      2:       return s[8] ? 8'hFF : s[7:0];
      default: return s[7:0];
    endcase
  endfunction

  always @(posedge clk) begin
    sum_l0_p1 <= adder_fn(op_a_l0, op_b_l0, 0);
    sum_l0_p2 <= sum_l0_p1;
    sum_l2_p1 <= adder_fn(op_a_l2, op_b_l2, 0);
    sum_l2_p2 <= sum_l2_p1;
  end

  assign sum_l0 = (mode == 3) ? sum_l0_p2 : adder_fn(op_a_l0, op_b_l0, mode);
  assign sum_l2 = (mode == 3) ? sum_l2_p2 : adder_fn(op_a_l2, op_b_l2, mode);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] s);
    logic [7:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 8'hB8;
    return r;
  endfunction

  task automatic model_vec(input int k, output logic [7:0] a, output logic [7:0] b);
    logic [7:0] l;
    l = 8'hA5;
    case (k)
      0: begin a = 8'h01; b = 8'h01; end
      1: begin a = 8'h0F; b = 8'h01; end
      2: begin a = 8'hFF; b = 8'h01; end
      3: begin a = 8'hAA; b = 8'h55; end
      default: begin
        for (int i = 0; i < k - 4; i++) l = step(l);
        a = l;
        b = 8'(k);
      end
    endcase
  endtask

  // Run one instance (sel 0: LAT=0, sel 1: LAT=2); edges = edge count at which done rose,
  // -1 on timeout, -2 when aborted by reset at rst_at. poke_at pulses start mid-run.
  task automatic do_run(input int sel, input int poke_at, input int rst_at, output int edges);
    int per;
    int idx;
    per = (sel != 0) ? 4 : 2;
    edges = -1;
    @(negedge clk);
    if (sel != 0) start_l2 = 1'b1; else start_l0 = 1'b1;
    @(posedge clk); #1;
    start_l0 = 1'b0;
    start_l2 = 1'b0;
    if (sel != 0) begin
      check("edge0_state_l2", {busy_l2, done_l2, fv_l2, err_l2, op_a_l2, op_b_l2}, {3'b100, 8'h00, 16'h0101});
      log_a[0] = op_a_l2; log_b[0] = op_b_l2;
    end else begin
      check("edge0_state_l0", {busy_l0, done_l0, fv_l0, err_l0, op_a_l0, op_b_l0}, {3'b100, 8'h00, 16'h0101});
      log_a[0] = op_a_l0; log_b[0] = op_b_l0;
    end
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk); #1;
      if (n == poke_at) begin
        if (sel != 0) start_l2 = 1'b1; else start_l0 = 1'b1;
      end
      if (n == poke_at + 1) begin
        start_l0 = 1'b0;
        start_l2 = 1'b0;
      end
      if (n == rst_at) begin
        #2 rst = 1'b1;
        #1;
        check("rst_ops_l0", {op_a_l0, op_b_l0, err_l0}, 32'h0);
        check("rst_flags_l0", {busy_l0, done_l0, pass_l0, fv_l0, fidx_l0}, 32'h0);
        edges = -2;
        break;
      end
      if ((sel != 0) ? done_l2 : done_l0) begin
        edges = n;
        break;
      end
      idx = n / per;
      if ((n % per) == 0 && idx < 64) begin
        log_a[idx] = (sel != 0) ? op_a_l2 : op_a_l0;
        log_b[idx] = (sel != 0) ? op_b_l2 : op_b_l0;
      end
    end
  endtask

  initial begin
    logic [7:0] exp_a [8];
    logic [7:0] exp_b [8];
    logic [7:0] ma, mb;
    logic [8:0] s9;
    int edges;
    int bad;
    int stuck_cnt;
    int sat_cnt;
    logic [7:0]  prev_err;
    logic [15:0] prev_fidx;

    exp_a = '{8'h01, 8'h0F, 8'hFF, 8'hAA, 8'hA5, 8'hEA, 8'h75, 8'h82};
    exp_b = '{8'h01, 8'h01, 8'h01, 8'h55, 8'h04, 8'h05, 8'h06, 8'h07};

    stuck_cnt = 0;
    sat_cnt = 0;
    for (int k = 0; k < 64; k++) begin
      model_vec(k, ma, mb);
      s9 = {1'b0, ma} + {1'b0, mb};
      if (s9[7]) stuck_cnt++;
      if (s9[8]) sat_cnt++;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_ops", {op_a_l0, op_b_l0, err_l0}, 32'h0);
    check("reset_flags", {busy_l0, done_l0, pass_l0, fv_l0, fidx_l0}, 32'h0);
    check("reset_flags_l2", {busy_l2, done_l2, pass_l2, fv_l2, fidx_l2}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Ideal adder, LAT=0
    mode = 0;
    do_run(0, -10, -10, edges);
    check("ideal_done_edge", edges, 128);
    check("ideal_result", {pass_l0, fv_l0, err_l0}, {2'b10, 8'h00});
    for (int k = 0; k < 8; k++)
      check($sformatf("vec%0d", k), {log_a[k], log_b[k]}, {exp_a[k], exp_b[k]});
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      model_vec(k, ma, mb);
      if (log_a[k] !== ma || log_b[k] !== mb) bad++;
    end
    check("vec_model_mismatches", bad, 0);
    ref_a = log_a;
    ref_b = log_b;

    // Bit 7 stuck at 0
    mode = 1;
    do_run(0, -10, -10, edges);
    check("stuck_done_edge", edges, 128);
    check("stuck_fail_idx", {fv_l0, fidx_l0}, {1'b1, 16'd3});
    check("stuck_err_count", err_l0, stuck_cnt);
    check("stuck_pass", pass_l0, 1'b0);

    // Saturating adder
    mode = 2;
    do_run(0, -10, -10, edges);
    check("sat_fail_idx", {fv_l0, fidx_l0}, {1'b1, 16'd2});
    check("sat_err_count", err_l0, sat_cnt);

    // Two-deep registered adder
    mode = 3;
    do_run(1, -10, -10, edges);
    check("pipe_lat2_done_edge", edges, 256);
    check("pipe_lat2_pass", {pass_l2, fv_l2, err_l2}, {2'b10, 8'h00});
    do_run(0, -10, -10, edges);
    check("pipe_lat0_pass", pass_l0, 1'b0);

    // Reset at mid-run, then clean rerun
    mode = 0;
    do_run(0, -10, 64, edges);
    check("rst_abort", edges, -2);
    @(negedge clk);
    rst = 1'b0;
    do_run(0, -10, -10, edges);
    check("rerun_done_edge", edges, 128);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (log_a[k] !== ref_a[k] || log_b[k] !== ref_b[k]) bad++;
    check("rerun_seq_mismatches", bad, 0);
    check("rerun_pass", pass_l0, 1'b1);

    // start while busy is ignored; start in DONE reruns identically
    mode = 1;
    do_run(0, 20, -10, edges);
    check("busy_start_done_edge", edges, 128);
    check("busy_start_err", err_l0, stuck_cnt);
    prev_err = err_l0;
    prev_fidx = fidx_l0;
    do_run(0, -10, -10, edges);
    check("done_restart_edge", edges, 128);
    check("done_restart_same", {err_l0, fidx_l0}, {prev_err, prev_fidx});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
